// File: rtl/tx_fifo_stage.sv
`default_nettype none
// ============================================================================
//  tx_fifo_stage : tags payload with a sync flag and periodically inserts a
//  blocklock sync word ahead of the tx lane FIFO.       Rev 1.0
// ============================================================================
module tx_fifo_stage #(
    parameter int WR_WIDTH    = 48,
    parameter int SYNC_PERIOD = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_enable,
    input  logic [WR_WIDTH-2:0] data_dist,
    input  logic                data_valid_dist,
    output logic                ready_dist,
    input  logic [3:0]          in_blocklock_local,
    input  logic                force_sync,
    input  logic                canpush_fifo,
    output logic                push_fifo,
    output logic [WR_WIDTH-1:0] data_fifo,
    output logic                out_sync_sent
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(SYNC_PERIOD - 1);
    localparam int                   c_PAD      = WR_WIDTH - 5;

    typedef enum logic {
        ST_DATA      = 1'b0,
        ST_SYNC_PEND = 1'b1
    } state_e;

    state_e                state_q,     state_d;
    logic [WR_WIDTH-1:0]   out_reg_q,   out_reg_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q,  word_cnt_d;
    logic                  sync_sent_q, sync_sent_d;

    logic w_push;
    logic w_load;
    logic w_sync_load;
    logic w_ready;
    logic w_accept;

    // The slot may be refilled in the same cycle it drains: one word per cycle.
    assign w_push      = out_valid_q & canpush_fifo & in_enable;
    assign w_load      = in_enable & (~out_valid_q | w_push);
    assign w_sync_load = w_load & (state_q == ST_SYNC_PEND);
    assign w_ready     = w_load & (state_q == ST_DATA);
    assign w_accept    = w_ready & data_valid_dist;

    assign push_fifo     = w_push;
    assign ready_dist    = w_ready;
    assign data_fifo     = out_reg_q;
    assign out_sync_sent = sync_sent_q;

    always_comb begin
        state_d     = state_q;
        out_reg_d   = out_reg_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;
        sync_sent_d = sync_sent_q;

        if (in_enable) begin
            sync_sent_d = w_push & out_reg_q[WR_WIDTH-1];
            // A force_sync arriving with the sync load is absorbed by it.
            if (w_sync_load) begin
                out_reg_d   = {1'b1, {c_PAD{1'b0}}, in_blocklock_local};
                out_valid_d = 1'b1;
                state_d     = ST_DATA;
                word_cnt_d  = '0;
            end else begin
                if (w_accept) begin
                    out_reg_d   = {1'b0, data_dist};
                    out_valid_d = 1'b1;
                    if (word_cnt_q == c_CNT_LAST) begin
                        word_cnt_d = '0;
                        state_d    = ST_SYNC_PEND;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end else if (w_push) begin
                    out_valid_d = 1'b0;
                end
                if (force_sync) begin
                    state_d = ST_SYNC_PEND;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_SYNC_PEND;
            out_reg_q   <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
            sync_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_reg_q   <= out_reg_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
            sync_sent_q <= sync_sent_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_stage.sv
`default_nettype none
// ============================================================================
//  tb_tx_fifo_stage : directed self-checking bench for tx_fifo_stage.
//  Rev 1.0
// ============================================================================
module tb_tx_fifo_stage;

    logic        clock;
    logic        reset_n;
    logic        in_enable;
    logic [46:0] data_dist;
    logic        data_valid_dist;
    logic        ready_dist;
    logic [3:0]  in_blocklock_local;
    logic        force_sync;
    logic        canpush_fifo;
    logic        push_fifo;
    logic [47:0] data_fifo;
    logic        out_sync_sent;

    logic        valid1;
    logic        ready1;
    logic        push1;
    logic [47:0] data1;
    logic        sent1;

    int          checks = 0;
    int          errors = 0;
    int          next_d = 0;
    int          rdy_low = 0;
    int          sync_cnt = 0;
    int          viol = 0;
    logic        last_rdy = 1'b0;
    bit          sel = 1'b0;
    logic [47:0] log0[$];
    logic [47:0] log1[$];

    tx_fifo_stage #(.WR_WIDTH(48), .SYNC_PERIOD(4), .CNT_WIDTH(16)) u_dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .in_enable          (in_enable),
        .data_dist          (data_dist),
        .data_valid_dist    (data_valid_dist),
        .ready_dist         (ready_dist),
        .in_blocklock_local (in_blocklock_local),
        .force_sync         (force_sync),
        .canpush_fifo       (canpush_fifo),
        .push_fifo          (push_fifo),
        .data_fifo          (data_fifo),
        .out_sync_sent      (out_sync_sent)
    );

    tx_fifo_stage #(.WR_WIDTH(48), .SYNC_PERIOD(1), .CNT_WIDTH(16)) u_one (
        .clock              (clock),
        .reset_n            (reset_n),
        .in_enable          (in_enable),
        .data_dist          (data_dist),
        .data_valid_dist    (valid1),
        .ready_dist         (ready1),
        .in_blocklock_local (in_blocklock_local),
        .force_sync         (force_sync),
        .canpush_fifo       (canpush_fifo),
        .push_fifo          (push1),
        .data_fifo          (data1),
        .out_sync_sent      (sent1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every FIFO write mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (push_fifo === 1'b1) log0.push_back(data_fifo);
        if (push1 === 1'b1) log1.push_back(data1);
        if (out_sync_sent === 1'b1) sync_cnt++;
        if (push_fifo === 1'b1 && canpush_fifo !== 1'b1) viol++;
    end

    function automatic logic [46:0] dpay(int n);
        return 47'h5A5A_0000_0000 + 47'(n);
    endfunction

    function automatic logic [47:0] ew(int e, logic [3:0] bl);
        if (e < 0) return {1'b1, 43'd0, bl};
        return {1'b0, dpay(e)};
    endfunction

    task automatic step();
        logic acc;
        @(negedge clock);
        if (sel) begin
            acc      = (ready1 === 1'b1) && valid1;
            last_rdy = ready1;
        end else begin
            acc      = (ready_dist === 1'b1) && data_valid_dist;
            last_rdy = ready_dist;
        end
        @(posedge clock);
        #1;
        if (acc) begin
            next_d++;
            data_dist = dpay(next_d);
        end
    endtask

    task automatic stream_until(int n);
        int g = 0;
        while (next_d < n && g < 200) begin
            step();
            if (last_rdy !== 1'b1) rdy_low++;
            g++;
        end
        checks++;
        if (next_d < n) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d words, required %0d", next_d, n);
        end
    endtask

    task automatic drain(int n);
        data_valid_dist = 1'b0;
        valid1          = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        in_enable          = 1'b1;
        data_valid_dist    = 1'b0;
        valid1             = 1'b0;
        force_sync         = 1'b0;
        canpush_fifo       = 1'b1;
        in_blocklock_local = 4'hA;
        next_d             = 0;
        data_dist          = dpay(0);
        step();
        step();
        log0.delete();
        log1.delete();
        sync_cnt = 0;
        rdy_low  = 0;
        reset_n  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        step();
        checks += 4;
        if (push_fifo !== 1'b0) begin errors++; $display("FAIL reset_push: got %b required 0", push_fifo); end
        if (data_fifo !== 48'd0) begin errors++; $display("FAIL reset_data: got %h required 0", data_fifo); end
        if (ready_dist !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", ready_dist); end
        if (out_sync_sent !== 1'b0) begin errors++; $display("FAIL reset_sent: got %b required 0", out_sync_sent); end
        reset_n = 1'b1;
        step();
        checks += 3;
        if (push_fifo !== 1'b1) begin errors++; $display("FAIL first_push: got %b required 1", push_fifo); end
        if (data_fifo !== ew(-1, 4'hA)) begin errors++; $display("FAIL first_sync_word: got %h required %h", data_fifo, ew(-1, 4'hA)); end
        if (push1 !== 1'b1) begin errors++; $display("FAIL first_push_p1: got %b required 1", push1); end
        step();
        checks += 2;
        if (push_fifo !== 1'b0) begin errors++; $display("FAIL idle_push: got %b required 0", push_fifo); end
        if (out_sync_sent !== 1'b1) begin errors++; $display("FAIL sync_sent_pulse: got %b required 1", out_sync_sent); end
        step();
        checks++;
        if (out_sync_sent !== 1'b0) begin errors++; $display("FAIL sync_sent_clear: got %b required 0", out_sync_sent); end
    endtask

    task automatic test_sync_period();
        int exp_i[$];
        exp_i = '{-1, 0, 1, 2, 3, -1, 4, 5, 6, 7, -1};
        do_reset();
        data_valid_dist = 1'b1;
        stream_until(8);
        drain(4);
        checks += 3;
        if (rdy_low != 2) begin errors++; $display("FAIL period_ready_low: got %0d cycles required 2", rdy_low); end
        if (sync_cnt != 3) begin errors++; $display("FAIL period_sync_pulses: got %0d required 3", sync_cnt); end
        if (log0.size() != exp_i.size()) begin errors++; $display("FAIL period_len: got %0d required %0d", log0.size(), exp_i.size()); end
        foreach (exp_i[i]) if (i < log0.size()) begin
            checks++;
            if (log0[i] !== ew(exp_i[i], 4'hA)) begin errors++; $display("FAIL period_word[%0d]: got %h required %h", i, log0[i], ew(exp_i[i], 4'hA)); end
        end
    endtask

    task automatic test_period_one();
        int exp_i[$];
        exp_i = '{-1, 0, -1, 1, -1, 2, -1};
        do_reset();
        sel    = 1'b1;
        valid1 = 1'b1;
        stream_until(3);
        drain(4);
        sel = 1'b0;
        checks++;
        if (log1.size() != exp_i.size()) begin errors++; $display("FAIL p1_len: got %0d required %0d", log1.size(), exp_i.size()); end
        foreach (exp_i[i]) if (i < log1.size()) begin
            checks++;
            if (log1[i] !== ew(exp_i[i], 4'hA)) begin errors++; $display("FAIL p1_word[%0d]: got %h required %h", i, log1[i], ew(exp_i[i], 4'hA)); end
        end
    endtask

    task automatic test_backpressure();
        int exp_i[$];
        exp_i = '{-1, 0, 1, 2, 3, -1, 4, 5, 6, 7, -1};
        do_reset();
        data_valid_dist = 1'b1;
        stream_until(2);
        canpush_fifo = 1'b0;
        repeat (5) begin
            #1;
            checks += 3;
            if (push_fifo !== 1'b0) begin errors++; $display("FAIL bp_push: got %b required 0", push_fifo); end
            if (ready_dist !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b required 0", ready_dist); end
            if (data_fifo !== ew(1, 4'hA)) begin errors++; $display("FAIL bp_hold: got %h required %h", data_fifo, ew(1, 4'hA)); end
            step();
        end
        canpush_fifo = 1'b1;
        stream_until(8);
        drain(4);
        checks++;
        if (log0.size() != exp_i.size()) begin errors++; $display("FAIL bp_len: got %0d required %0d", log0.size(), exp_i.size()); end
        foreach (exp_i[i]) if (i < log0.size()) begin
            checks++;
            if (log0[i] !== ew(exp_i[i], 4'hA)) begin errors++; $display("FAIL bp_word[%0d]: got %h required %h", i, log0[i], ew(exp_i[i], 4'hA)); end
        end
    endtask

    task automatic test_force_sync();
        int exp_a[$];
        int exp_b[$];
        exp_a = '{-1, 0, 1, 2, -1, 3, 4, 5, 6, -1};
        exp_b = '{-1, 0, 1, 2, -1, 3, 4, 5, 6, -1, 7};
        // Idle force, then a second force coincident with the sync load.
        do_reset();
        data_valid_dist = 1'b1;
        stream_until(3);
        data_valid_dist = 1'b0;
        force_sync      = 1'b1;
        step();
        step();
        force_sync      = 1'b0;
        data_valid_dist = 1'b1;
        stream_until(7);
        drain(4);
        checks++;
        if (log0.size() != exp_a.size()) begin errors++; $display("FAIL force_len: got %0d required %0d", log0.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < log0.size()) begin
            checks++;
            if (log0[i] !== ew(exp_a[i], 4'hA)) begin errors++; $display("FAIL force_word[%0d]: got %h required %h", i, log0[i], ew(exp_a[i], 4'hA)); end
        end
        // Force coincident with a data accept: data first, then sync.
        do_reset();
        data_valid_dist = 1'b1;
        stream_until(2);
        force_sync = 1'b1;
        step();
        force_sync = 1'b0;
        stream_until(8);
        drain(4);
        checks++;
        if (log0.size() != exp_b.size()) begin errors++; $display("FAIL force_acc_len: got %0d required %0d", log0.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < log0.size()) begin
            checks++;
            if (log0[i] !== ew(exp_b[i], 4'hA)) begin errors++; $display("FAIL force_acc_word[%0d]: got %h required %h", i, log0[i], ew(exp_b[i], 4'hA)); end
        end
    endtask

    task automatic test_enable_toggle();
        int          exp_i[$];
        int          g = 0;
        logic        en_t = 1'b1;
        logic [47:0] pd;
        logic        ps;
        exp_i = '{-1, 0, 1, 2, 3, -1, 4, 5, 6, 7, -1};
        do_reset();
        data_valid_dist = 1'b1;
        while (next_d < 8 && g < 200) begin
            in_enable  = en_t;
            force_sync = ~en_t;
            pd = data_fifo;
            ps = out_sync_sent;
            if (!en_t) begin
                #1;
                checks += 2;
                if (push_fifo !== 1'b0) begin errors++; $display("FAIL en_push: got %b required 0", push_fifo); end
                if (ready_dist !== 1'b0) begin errors++; $display("FAIL en_ready: got %b required 0", ready_dist); end
            end
            step();
            if (!en_t) begin
                checks += 2;
                if (data_fifo !== pd) begin errors++; $display("FAIL en_freeze_data: got %h required %h", data_fifo, pd); end
                if (out_sync_sent !== ps) begin errors++; $display("FAIL en_freeze_sent: got %b required %b", out_sync_sent, ps); end
            end
            en_t = ~en_t;
            g++;
        end
        in_enable  = 1'b1;
        force_sync = 1'b0;
        checks++;
        if (next_d < 8) begin errors++; $display("FAIL en_timeout: accepted %0d required 8", next_d); end
        drain(4);
        checks++;
        if (log0.size() != exp_i.size()) begin errors++; $display("FAIL en_len: got %0d required %0d", log0.size(), exp_i.size()); end
        foreach (exp_i[i]) if (i < log0.size()) begin
            checks++;
            if (log0[i] !== ew(exp_i[i], 4'hA)) begin errors++; $display("FAIL en_word[%0d]: got %h required %h", i, log0[i], ew(exp_i[i], 4'hA)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_valid_dist = 1'b1;
        stream_until(6);
        data_valid_dist = 1'b0;
        canpush_fifo    = 1'b0;
        step();
        step();
        checks++;
        if (data_fifo !== ew(5, 4'hA)) begin errors++; $display("FAIL mid_slot: got %h required %h", data_fifo, ew(5, 4'hA)); end
        reset_n            = 1'b0;
        in_blocklock_local = 4'h3;
        step();
        checks += 2;
        if (push_fifo !== 1'b0) begin errors++; $display("FAIL mid_reset_push: got %b required 0", push_fifo); end
        if (data_fifo !== 48'd0) begin errors++; $display("FAIL mid_reset_data: got %h required 0", data_fifo); end
        log0.delete();
        reset_n      = 1'b1;
        canpush_fifo = 1'b1;
        drain(4);
        checks++;
        if (log0.size() != 1) begin errors++; $display("FAIL mid_len: got %0d required 1", log0.size()); end
        if (log0.size() > 0) begin
            checks++;
            if (log0[0] !== ew(-1, 4'h3)) begin errors++; $display("FAIL mid_sync: got %h required %h", log0[0], ew(-1, 4'h3)); end
        end
    endtask

    task automatic test_invariant();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL push_without_room: got %0d events required 0", viol); end
    endtask

    initial begin
        test_reset();
        test_sync_period();
        test_period_one();
        test_backpressure();
        test_force_sync();
        test_enable_toggle();
        test_reset_mid();
        test_invariant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_fifo_stage.md
Name: tx_fifo_stage

Overview:
- Transmit-side counterpart of the receive fifo stage in the PCS lane path.
- Accepts (WR_WIDTH-1)-bit data words from the tx distributor and prepends a sync flag bit (MSB) to form WR_WIDTH-bit words.
- Pushes those words into the tx lane FIFO through a single registered output slot.
- Periodically inserts a sync word carrying the local 4-bit blocklock status; the far-end receive stage extracts it as remote blocklock.

Parameters:
- WR_WIDTH, 48: FIFO word width. MSB = sync flag; the lower WR_WIDTH-1 bits are payload.
- SYNC_PERIOD, 16: number of data words accepted between automatic sync insertions. Legal range is 1 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 16: width of the data-word counter.

Ports:
- clock  input  1  clock
- reset_n  input  1  reset, synchronous, active-low
- in_enable  input  1  clock-enable; when low, all state holds and handshakes are blocked
- data_dist  input  WR_WIDTH-1  payload from distributor
- data_valid_dist  input  1  data_dist is valid
- ready_dist  output  1  stage accepts data_dist this cycle
- in_blocklock_local  input  4  local lane blocklock status
- force_sync  input  1  one-cycle request to insert a sync word as soon as possible
- canpush_fifo  input  1  tx FIFO not full
- push_fifo  output  1  write data_fifo into FIFO this cycle
- data_fifo  output  WR_WIDTH  FIFO write word (registered)
- out_sync_sent  output  1  registered pulse: a sync word was pushed in the previous cycle

Behaviour:
- State:
  - out_reg[WR_WIDTH-1:0] and out_valid (output slot).
  - sync_pend flag (two states: SYNC_PEND=1, DATA=0).
  - word_cnt[CNT_WIDTH-1:0].
- Reset values: out_reg=0, out_valid=0, sync_pend=1, word_cnt=0, out_sync_sent=0.
  - Therefore push_fifo=0, data_fifo=0 and ready_dist=0 while reset is applied.
  - Because sync_pend resets to 1, the first word pushed after reset is always a sync word.
- push_fifo = out_valid & canpush_fifo & in_enable (combinational); data_fifo = out_reg.
- load = in_enable & (!out_valid | push_fifo). The slot can be refilled in the same cycle it is drained, so throughput is one word per cycle.
- ready_dist = load & !sync_pend. While a sync is pending, the distributor is stalled.
- accept = ready_dist & data_valid_dist.
- Slot update, evaluated in priority order:
  1. load & sync_pend: out_reg <= {1'b1, zeros, in_blocklock_local} (bits [3:0] = blocklock, sampled this cycle). Set out_valid=1, clear sync_pend, word_cnt <= 0.
  2. accept: out_reg <= {1'b0, data_dist}; out_valid=1.
  3. push_fifo & !accept: out_valid <= 0.
  4. Otherwise hold.
- Counter:
  - On accept, if word_cnt == SYNC_PERIOD-1, then word_cnt <= 0 and sync_pend <= 1.
  - Otherwise, on accept, word_cnt increments.
  - With SYNC_PERIOD=1, the output alternates S,D,S,D.
- force_sync:
  - Sets sync_pend=1 on any enabled cycle.
  - If asserted in the cycle a sync word loads, it is absorbed (sync_pend ends at 0); no back-to-back duplicate sync is produced.
  - If asserted while sync_pend is already 1, it has no extra effect.
  - If asserted in the same cycle as an accept, the data word loads first and the sync follows on the next load.
- Sync insertion resets word_cnt to 0, including forced syncs.
- out_sync_sent <= push_fifo & out_reg[WR_WIDTH-1], registered, updated only when in_enable=1. When in_enable=0 it holds its value, so a pulse present when in_enable falls persists until the next enabled cycle.
- Backpressure: when canpush_fifo=0, out_reg and out_valid hold. ready_dist=0 whenever out_valid=1. No word is dropped or duplicated.
- in_enable=0: no register updates, push_fifo=0, ready_dist=0, and force_sync is ignored.
- Reset mid-operation: the word in the slot is discarded, the counter clears, and the next push is a sync word.
- Invariant: push_fifo implies canpush_fifo. Each accepted data word appears exactly once in FIFO order, with MSB=0.

Test Plan:
- Reset, in_blocklock_local=4'hA, canpush_fifo=1, no data -> first push is data_fifo = {1,0...,4'hA}; out_sync_sent=1 the next cycle; then push_fifo=0.
- SYNC_PERIOD=4, continuous valid data D0..D7 -> pushed sequence S,D0,D1,D2,D3,S,D4,D5,D6,D7,S. ready_dist is low for exactly one cycle before each S.
- After lock, canpush_fifo=0 for 5 cycles mid-stream -> push_fifo=0, data_fifo holds D(n), ready_dist=0. On release, D(n) is pushed once and the stream resumes with no gaps or duplicates.
- SYNC_PERIOD=16, pulse force_sync after D2 -> next word pushed is S; word_cnt restarts, so the next automatic S follows 16 data words later. A force_sync coincident with the S load causes no second S.
- Toggle in_enable 1/0 every cycle with continuous data -> at most one push per enabled cycle, ordering intact, all state frozen on disabled cycles.
- Assert reset_n=0 while the slot holds D5 and canpush_fifo=0 -> after release, D5 is never pushed and the first push is S carrying the current in_blocklock_local.
